// File: rtl/dfdd_pkg.sv
// Shared types and constants for the horizontal 2:1 FP16 window generator.
package dfdd_pkg;

  localparam int unsigned FP16_WIDTH = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVEN,
    S_ODD
  } state_t;

  typedef logic [FP16_WIDTH-1:0] pixel_t;

  // IEEE half-precision +0.0
  localparam pixel_t FP_ZERO = '0;

endpackage

// File: rtl/downsampler_h_window_fp16.sv
// Horizontal 2:1 decimating 1x4 window generator for a streaming FP16 raster.
// Each output window k spans input columns 2k-1..2k+2 and is emitted one cycle
// after the beat that completes it. Edges replicate the outermost pixel unless
// DOWNSAMPLER_EDGE_ZERO_EN is defined, in which case edge taps are +0.0.
module downsampler_h_window_fp16
  import dfdd_pkg::*;
#(
  parameter int unsigned EXP_WIDTH   = 5,
  parameter int unsigned FRAC_WIDTH  = 10,
  parameter int unsigned IMAGE_WIDTH = 640
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [1+EXP_WIDTH+FRAC_WIDTH-1:0]    data_i,
  input  logic [15:0]                          col_i,
  input  logic [15:0]                          row_i,
  input  logic                                 valid_i,
  output logic [1+EXP_WIDTH+FRAC_WIDTH-1:0]    window_o [1][4],
  output logic [15:0]                          col_o,
  output logic [15:0]                          row_o,
  output logic                                 valid_o
);

  localparam int unsigned FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH;
  localparam logic [15:0] LAST_COL     = 16'(IMAGE_WIDTH - 1);
  localparam logic [FP_WIDTH_REG-1:0] PIX_ZERO = FP_WIDTH_REG'(FP_ZERO);

  // Row width must allow at least two complete windows and pair up evenly
  if (((IMAGE_WIDTH % 2) != 0) || (IMAGE_WIDTH < 4)) begin : g_bad_width
    $error("IMAGE_WIDTH must be even and at least 4");
  end

  state_t                    state_q, state_d;
  logic [FP_WIDTH_REG-1:0]   t_m1_q, t_m1_d;
  logic [FP_WIDTH_REG-1:0]   t_0_q, t_0_d;
  logic [FP_WIDTH_REG-1:0]   t_1_q, t_1_d;
  logic [15:0]               row_lat_q, row_lat_d;
  logic [FP_WIDTH_REG-1:0]   win_d [1][4];
  logic [15:0]               col_d;
  logic [15:0]               row_d;
  logic                      emit_d;
  logic [FP_WIDTH_REG-1:0]   left_tap;
  logic [FP_WIDTH_REG-1:0]   right_tap;

`ifdef DOWNSAMPLER_EDGE_ZERO_EN
  // Edge taps outside the image read as +0.0
  assign left_tap  = PIX_ZERO;
  assign right_tap = PIX_ZERO;
`else
  // Edge taps outside the image replicate the outermost pixel
  assign left_tap  = data_i;
  assign right_tap = data_i;
`endif

  // Next-state, tap update and emission decode
  always_comb begin
    state_d   = state_q;
    t_m1_d    = t_m1_q;
    t_0_d     = t_0_q;
    t_1_d     = t_1_q;
    row_lat_d = row_lat_q;
    win_d     = window_o;
    col_d     = col_o;
    row_d     = row_o;
    emit_d    = 1'b0;

    if (valid_i) begin
      if (col_i == 16'd0) begin
        // Start of row from any state; a pending partial window is dropped
        t_m1_d    = left_tap;
        t_0_d     = data_i;
        row_lat_d = row_i;
        state_d   = S_EVEN;
      end else begin
        case (state_q)
          S_EVEN: begin
            if (col_i[0]) begin
              if (col_i == LAST_COL) begin
                win_d[0][0] = t_m1_q;
                win_d[0][1] = t_0_q;
                win_d[0][2] = data_i;
                win_d[0][3] = right_tap;
                col_d       = col_i >> 1;
                row_d       = row_lat_q;
                emit_d      = 1'b1;
                state_d     = S_IDLE;
              end else begin
                t_1_d   = data_i;
                state_d = S_ODD;
              end
            end
          end
          S_ODD: begin
            if (!col_i[0]) begin
              win_d[0][0] = t_m1_q;
              win_d[0][1] = t_0_q;
              win_d[0][2] = t_1_q;
              win_d[0][3] = data_i;
              col_d       = (col_i >> 1) - 16'd1;
              row_d       = row_lat_q;
              emit_d      = 1'b1;
              t_m1_d      = t_1_q;
              t_0_d       = data_i;
              state_d     = S_EVEN;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // State, tap and registered-output update with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      t_m1_q    <= PIX_ZERO;
      t_0_q     <= PIX_ZERO;
      t_1_q     <= PIX_ZERO;
      row_lat_q <= 16'd0;
      for (int j = 0; j < 4; j++) window_o[0][j] <= PIX_ZERO;
      col_o     <= 16'd0;
      row_o     <= 16'd0;
      valid_o   <= 1'b0;
    end else begin
      state_q   <= state_d;
      t_m1_q    <= t_m1_d;
      t_0_q     <= t_0_d;
      t_1_q     <= t_1_d;
      row_lat_q <= row_lat_d;
      for (int j = 0; j < 4; j++) window_o[0][j] <= win_d[0][j];
      col_o     <= col_d;
      row_o     <= row_d;
      valid_o   <= emit_d;
    end
  end

endmodule
